// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU with iterative multiply/divide:
// op-code map, handshake FSM states and op-class helpers.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_SLT    = 5'b00010;
    localparam logic [4:0] OP_SLTU   = 5'b00011;
    localparam logic [4:0] OP_OR     = 5'b00100;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_XOR    = 5'b00111;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SLL    = 5'b01001;
    localparam logic [4:0] OP_SRA    = 5'b01010;
    localparam logic [4:0] OP_PASSB  = 5'b01101;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Real M-extension ops; 11xxx codes are treated as single-cycle "return 0".
    function automatic logic is_mdu(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

endpackage

// File: rtl/RippleAdder.sv
// Plain ripple-carry adder with carry-in/carry-out, shared by ADD and SUB.
module RippleAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic w_carry;

    // Bit-serial carry chain evaluated as a loop to keep the carry a local variable.
    always_comb begin
        o_sum   = '0;
        w_carry = i_cin;
        for (int i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/alu_iter_mdu.sv
// Iterative multiply (shift-add) and restoring divide on operand magnitudes,
// with sign fixup applied on the way out.
module alu_iter_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_abort,
    input  logic             i_start,
    input  logic [4:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_MUL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_DIV_LAST = CW'(WIDTH);

    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_is_div;
    logic                 r_hi_sel;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_sa;
    logic                 w_sb;
    logic                 w_is_div;
    logic                 w_sel;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic                 w_neg_res;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_div_val;

    // Op decode: operand signedness and which half (hi/rem) the caller wants.
    always_comb begin
        w_sa     = 1'b0;
        w_sb     = 1'b0;
        w_is_div = 1'b0;
        w_sel    = 1'b0;
        case (i_op)
            OP_MUL:    begin w_sa = 1'b1; w_sb = 1'b1; end
            OP_MULH:   begin w_sa = 1'b1; w_sb = 1'b1; w_sel = 1'b1; end
            OP_MULHSU: begin w_sa = 1'b1; w_sel = 1'b1; end
            OP_MULHU:  begin w_sel = 1'b1; end
            OP_DIV:    begin w_is_div = 1'b1; w_sa = 1'b1; w_sb = 1'b1; end
            OP_DIVU:   begin w_is_div = 1'b1; end
            OP_REM:    begin w_is_div = 1'b1; w_sa = 1'b1; w_sb = 1'b1; w_sel = 1'b1; end
            OP_REMU:   begin w_is_div = 1'b1; w_sel = 1'b1; end
            default:   begin w_sa = 1'b0; end
        endcase
        w_neg_a   = w_sa & i_a[WIDTH-1];
        w_neg_b   = w_sb & i_b[WIDTH-1];
        w_mag_a   = w_neg_a ? -i_a : i_a;
        w_mag_b   = w_neg_b ? -i_b : i_b;
        // A remainder takes the dividend's sign; everything else the XOR of signs.
        w_neg_res = (w_is_div && w_sel) ? w_neg_a : (w_neg_a ^ w_neg_b);
    end

    // One iteration step for each algorithm plus the sign-corrected result.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_mcand};
        if (!w_div_diff[WIDTH]) begin
            w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_div_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
        w_prod    = r_neg ? -w_mul_next : w_mul_next;
        w_div_val = r_hi_sel ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
        if (r_is_div) begin
            o_result = r_neg ? -w_div_val : w_div_val;
            o_done   = r_busy && (r_cnt == CNT_DIV_LAST);
        end else begin
            // The last multiply step is folded into the output so latency stays WIDTH+1.
            o_result = r_hi_sel ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
            o_done   = r_busy && (r_cnt == CNT_MUL_LAST);
        end
    end

    // Iteration state: load on start, step each cycle, stop on done or abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_hi_sel <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_hi_sel <= w_sel;
            r_neg    <= w_neg_res;
            r_mcand  <= w_mag_b;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
        end else if (r_busy) begin
            if (o_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
                r_acc <= r_is_div ? w_div_next : w_mul_next;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked execute-stage ALU: single-cycle base ops, iterative M ops,
// registered result with z/c/v flags.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;

    logic             w_accept;
    logic             w_go_iter;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_fast_res;
    logic             w_fast_c;
    logic             w_fast_v;
    logic             w_mdu_done;
    logic [WIDTH-1:0] w_mdu_res;

    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_is_sub = (op == OP_SUB);
    assign w_b_eff  = w_is_sub ? ~b : b;
    assign w_shamt  = b[SHW-1:0];

    RippleAdder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (a),
        .i_b    (w_b_eff),
        .i_cin  (w_is_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    alu_iter_mdu #(.WIDTH(WIDTH)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_abort  (flush),
        .i_start  (w_accept && w_go_iter),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_mdu_done),
        .o_result (w_mdu_res)
    );

    // Single-cycle result path: base ops, divide special cases and unused codes.
    always_comb begin
        w_fast_res = '0;
        w_fast_c   = 1'b0;
        w_fast_v   = 1'b0;
        w_go_iter  = 1'b0;
        if (!op[4]) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    w_fast_res = w_sum;
                    w_fast_c   = w_cout;
                    w_fast_v   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                end
                OP_AND:   w_fast_res = a & b;
                OP_OR:    w_fast_res = a | b;
                OP_XOR:   w_fast_res = a ^ b;
                OP_SLL:   w_fast_res = a << w_shamt;
                OP_SRL:   w_fast_res = a >> w_shamt;
                OP_SRA:   w_fast_res = $signed(a) >>> w_shamt;
                OP_PASSB: w_fast_res = b;
                OP_SLT:   w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                OP_SLTU:  w_fast_res = {{(WIDTH-1){1'b0}}, (a < b)};
                default:  w_fast_res = '0;
            endcase
        end else if (is_mdu(op)) begin
            if (is_div(op) && (b == '0)) begin
                w_fast_res = op[1] ? a : '1;
            end else if (is_div(op) && !op[0] && (a == MIN_VAL) && (b == '1)) begin
                // MIN / -1 cannot be represented; pin to MIN / 0 without flagging v.
                w_fast_res = op[1] ? '0 : MIN_VAL;
            end else begin
                w_go_iter = 1'b1;
            end
        end else begin
            w_fast_res = '0;
        end
    end

    // Handshake FSM and registered result/flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            alu_out   <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
        end else if (flush) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
        end else if (w_accept) begin
            if (w_go_iter) begin
                r_state   <= is_div(op) ? ST_DIV : ST_MUL;
                out_valid <= 1'b0;
            end else begin
                r_state   <= ST_DONE;
                out_valid <= 1'b1;
                alu_out   <= w_fast_res;
                z         <= (w_fast_res == '0);
                c         <= w_fast_c;
                v         <= w_fast_v;
            end
        end else begin
            case (r_state)
                ST_MUL, ST_DIV: begin
                    if (w_mdu_done) begin
                        r_state   <= ST_DONE;
                        out_valid <= 1'b1;
                        alu_out   <= w_mdu_res;
                        z         <= (w_mdu_res == '0);
                        c         <= 1'b0;
                        v         <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv: 32-bit instance plus a 16-bit build.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'b00000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_out;
    logic        z, c, v;

    logic        iv16 = 1'b0;
    logic        ir16;
    logic [4:0]  op16 = 5'b00000;
    logic [15:0] a16 = 16'h0;
    logic [15:0] b16 = 16'h0;
    logic        ov16;
    logic [15:0] res16;
    logic        z16, c16, v16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .z(z), .c(c), .v(v)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(1'b1), .alu_out(res16),
        .z(z16), .c(c16), .v(v16)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op, then count edges (accept edge = 1) until out_valid.
    task automatic run_op(input logic [4:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          output int lat, output logic saw_ready);
        @(negedge clk);
        op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [4:0] op_i, input logic [31:0] a_i,
                           input logic [31:0] b_i, input logic [31:0] exp_res, input int exp_lat,
                           input logic exp_c, input logic exp_v);
        int   lat;
        logic saw;
        run_op(op_i, a_i, b_i, lat, saw);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, alu_out, exp_res);
        check_eq({tag, "_z"}, z, (exp_res == 32'h0));
        check_eq({tag, "_c"}, c, exp_c);
        check_eq({tag, "_v"}, v, exp_v);
        if (exp_lat > 1) check_eq({tag, "_inrdy_busy"}, saw, 1'b0);
    endtask

    initial begin
        int   lat;
        logic rose;
        logic [31:0] held;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_alu_out", alu_out, 32'h0);
        check_eq("rst_flags", {z, c, v}, 3'b000);
        check_eq("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("ADD_ovf",  5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 1'b0, 1'b1);
        run_vec("SUB_eq",   5'b00001, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1'b1, 1'b0);
        run_vec("SUB_brw",  5'b00001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1, 1'b0, 1'b0);
        run_vec("SUB_ovf",  5'b00001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1'b1, 1'b1);
        run_vec("AND",      5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 1'b0, 1'b0);
        run_vec("OR",       5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1, 1'b0, 1'b0);
        run_vec("XOR",      5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 1'b0, 1'b0);
        run_vec("SLL",      5'b01001, 32'h00000001, 32'h00000021, 32'h00000002, 1, 1'b0, 1'b0);
        run_vec("SRL",      5'b01000, 32'h80000000, 32'h00000024, 32'h08000000, 1, 1'b0, 1'b0);
        run_vec("SRA",      5'b01010, 32'h80000000, 32'h00000024, 32'hF8000000, 1, 1'b0, 1'b0);
        run_vec("SLTU",     5'b00011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0, 1'b0);
        run_vec("SLT",      5'b00010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0, 1'b0);
        run_vec("PASSB",    5'b01101, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b0, 1'b0);
        run_vec("BASE_UND", 5'b00110, 32'h00000001, 32'h00000001, 32'h00000000, 1, 1'b0, 1'b0);
        run_vec("OP_11X",   5'b11000, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1'b0, 1'b0);
        run_vec("MULH",     5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b0, 1'b0);
        run_vec("MULHU",    5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, 1'b0);
        run_vec("MUL",      5'b10000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, 1'b0);
        run_vec("MULHSU",   5'b10010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 1'b0, 1'b0);
        run_vec("DIV",      5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, 1'b0, 1'b0);
        run_vec("REM",      5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, 1'b0, 1'b0);
        run_vec("DIVU",     5'b10101, 32'h00000064, 32'h00000007, 32'h0000000E, 34, 1'b0, 1'b0);
        run_vec("REMU",     5'b10111, 32'h00000064, 32'h00000007, 32'h00000002, 34, 1'b0, 1'b0);
        run_vec("DIVU_b0",  5'b10101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1, 1'b0, 1'b0);
        run_vec("REM_b0",   5'b10110, 32'h00001234, 32'h00000000, 32'h00001234, 1, 1'b0, 1'b0);
        run_vec("DIV_ovf",  5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0, 1'b0);
        run_vec("REM_ovf",  5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0, 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_vec("BP_ADD", 5'b00000, 32'h00000003, 32'h00000004, 32'h00000007, 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_res", alu_out, 32'h00000007);
            check_eq("bp_hold_vld_flags", {out_valid, z, c, v}, 4'b1000);
            check_eq("bp_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        op = 5'b00000; a = 32'h0000000A; b = 32'h00000014; in_valid = 1'b1;
        #1;
        check_eq("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_b2b_valid", out_valid, 1'b1);
        check_eq("bp_b2b_res", alu_out, 32'h0000001E);

        // Flush ten cycles into a divide; the op presented with flush is dropped.
        held = alu_out;
        @(negedge clk);
        op = 5'b10100; a = 32'hFFFFFFF9; b = 32'h00000002; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        op = 5'b00000; a = 32'h00000001; b = 32'h00000001; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_ready", in_ready, 1'b1);
        check_eq("flush_alu_hold", alu_out, held);
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1'b1;
        end
        check_eq("flush_no_result", rose, 1'b0);
        run_vec("POSTFLUSH_DIVU", 5'b10101, 32'h00000064, 32'h00000007, 32'h0000000E, 34, 1'b0, 1'b0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        op = 5'b10000; a = 32'h00000007; b = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_alu_out", alu_out, 32'h0);
        check_eq("midrst_flags", {z, c, v}, 3'b000);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1'b1;
        end
        check_eq("midrst_no_result", rose, 1'b0);
        run_vec("POSTRST_MUL", 5'b10000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, 1'b0);

        // 16-bit build.
        @(negedge clk);
        op16 = 5'b10011; a16 = 16'hFFFF; b16 = 16'hFFFF; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w16_mulhu_lat", lat, 17);
        check_eq("w16_mulhu_res", res16, 16'hFFFE);
        check_eq("w16_mulhu_flags", {z16, c16, v16}, 3'b000);
        check_eq("w16_done_in_ready", ir16, 1'b1);
        @(negedge clk);
        op16 = 5'b00000; a16 = 16'h7FFF; b16 = 16'h0001; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        check_eq("w16_add_valid", ov16, 1'b1);
        check_eq("w16_add_res", res16, 16'h8000);
        check_eq("w16_add_flags", {z16, c16, v16}, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
